// File: rtl/sprite_collision_detect_if.sv
// Snoop/dump bundle for sprite_collision_detect.
//  master: the line-engine/CPU side that drives the pixel snoop and vblank and
//          receives the collision RAM write port, the IRQ and busy.
//  slave : the collision detector.
//  line_start, pix_wr, pix_x[8:0], pix_index[4:0], vblank           -> detector
//  spritecollisionram_addr[6:0], _data[7:0], _wr, coll_irq, busy    <- detector
interface sprite_collision_detect_if;
  logic       line_start;
  logic       pix_wr;
  logic [8:0] pix_x;
  logic [4:0] pix_index;
  logic       vblank;
  logic [6:0] spritecollisionram_addr;
  logic [7:0] spritecollisionram_data;
  logic       spritecollisionram_wr;
  logic       coll_irq;
  logic       busy;

  modport master (
    output line_start, pix_wr, pix_x, pix_index, vblank,
    input  spritecollisionram_addr, spritecollisionram_data,
           spritecollisionram_wr, coll_irq, busy
  );

  modport slave (
    input  line_start, pix_wr, pix_x, pix_index, vblank,
    output spritecollisionram_addr, spritecollisionram_data,
           spritecollisionram_wr, coll_irq, busy
  );
endinterface

// File: rtl/sprite_collision_detect.sv
// Sprite collision detector.
//  Snoops opaque sprite pixels, keeps a per-line owner buffer (512 x {valid,idx})
//  and flags pixels written by two different sprites. Per frame it accumulates a
//  hit bit and first partner per sprite; on vblank rise it writes 32 bytes
//  {hit, 2'b00, partner} into collision RAM and pulses coll_irq if any hit.
//  Ports: clk, reset (sync, active-low), bus (slave modport of
//  sprite_collision_detect_if: pixel snoop in, collision RAM/IRQ/busy out).
module sprite_collision_detect #(
  parameter int         LINE_MAX  = 352,
  parameter logic [6:0] COLL_BASE = 7'd0
) (
  input logic                      clk,
  input logic                      reset,
  sprite_collision_detect_if.slave bus
);
  localparam logic [8:0] LMAX = 9'(LINE_MAX);

  typedef enum logic {L_CLEAR, L_ACTIVE} line_st_t;
  typedef enum logic {D_IDLE, D_DUMP}    dump_st_t;

  function automatic logic [7:0] entry(input logic h, input logic [4:0] p);
    return {h, 2'b00, (h ? p : 5'd0)};
  endfunction

  // owner buffer
  logic [5:0] owner_mem [512];
  logic [5:0] owner_rd_q;
  logic       mem_we;
  logic [8:0] mem_wa;
  logic [5:0] mem_wd;

  line_st_t        line_st_q, line_st_d;
  logic [8:0]      clr_x_q, clr_x_d;
  logic            s1_vld_q, s1_vld_d;
  logic [8:0]      s1_x_q, s1_x_d;
  logic [4:0]      s1_idx_q, s1_idx_d;
  logic            fwd_q, fwd_d;
  logic [4:0]      fwd_idx_q, fwd_idx_d;
  logic [31:0]     accum_q, accum_d;
  logic [31:0][4:0] partner_q, partner_d;
  logic [31:0]     snap_q, snap_d;
  logic [31:0][4:0] spart_q, spart_d;
  dump_st_t        dump_st_q, dump_st_d;
  logic [5:0]      cnt_q, cnt_d;
  logic            vblank_q;
  logic            wr_q, wr_d;
  logic [6:0]      addr_q, addr_d;
  logic [7:0]      data_q, data_d;
  logic            irq_q, irq_d;

  logic            accept, prev_v, hit, vb_rise;
  logic [4:0]      prev_idx;
  logic [31:0]     acc_nxt;
  logic [31:0][4:0] part_nxt;

  // S1 compare: a same-x write from the stage ahead was not yet visible to the
  // read issued alongside it, so take its idx directly.
  always_comb begin
    accept   = (line_st_q == L_ACTIVE) && !bus.line_start && bus.pix_wr;
    prev_v   = fwd_q | owner_rd_q[5];
    prev_idx = fwd_q ? fwd_idx_q : owner_rd_q[4:0];
    hit      = s1_vld_q && prev_v && (prev_idx != s1_idx_q);
    vb_rise  = bus.vblank && !vblank_q;

    acc_nxt  = accum_q;
    part_nxt = partner_q;
    if (hit) begin
      if (!accum_q[s1_idx_q]) part_nxt[s1_idx_q] = prev_idx;
      if (!accum_q[prev_idx]) part_nxt[prev_idx] = s1_idx_q;
      acc_nxt[s1_idx_q] = 1'b1;
      acc_nxt[prev_idx] = 1'b1;
    end

    // single write port: clear sweep and pixel commit never overlap
    mem_we = s1_vld_q || (line_st_q == L_CLEAR);
    mem_wa = s1_vld_q ? s1_x_q : clr_x_q;
    mem_wd = s1_vld_q ? {1'b1, s1_idx_q} : 6'd0;
  end

  always_ff @(posedge clk) begin
    if (mem_we) owner_mem[mem_wa] <= mem_wd;
    owner_rd_q <= owner_mem[bus.pix_x];
  end

  // line FSM + S0 capture
  always_comb begin
    line_st_d = line_st_q;
    clr_x_d   = clr_x_q;
    case (line_st_q)
      L_CLEAR: begin
        if (bus.line_start)      clr_x_d = 9'd0;
        else if (clr_x_q == LMAX) line_st_d = L_ACTIVE;
        else                     clr_x_d = clr_x_q + 9'd1;
      end
      default: begin
        if (bus.line_start) begin
          line_st_d = L_CLEAR;
          clr_x_d   = 9'd0;
        end
      end
    endcase
    s1_vld_d  = accept;
    s1_x_d    = bus.pix_x;
    s1_idx_d  = bus.pix_index;
    fwd_d     = accept && s1_vld_q && (s1_x_q == bus.pix_x);
    fwd_idx_d = s1_idx_q;
  end

  // dump FSM; hits landing on the rise cycle are folded into the snapshot
  always_comb begin
    dump_st_d = dump_st_q;
    cnt_d     = cnt_q;
    snap_d    = snap_q;
    spart_d   = spart_q;
    accum_d   = acc_nxt;
    partner_d = part_nxt;
    wr_d      = 1'b0;
    addr_d    = 7'd0;
    data_d    = 8'd0;
    irq_d     = 1'b0;
    case (dump_st_q)
      D_IDLE: begin
        if (vb_rise) begin
          snap_d    = acc_nxt;
          spart_d   = part_nxt;
          accum_d   = '0;
          partner_d = '0;
          dump_st_d = D_DUMP;
          cnt_d     = 6'd1;
          wr_d      = 1'b1;
          addr_d    = COLL_BASE;
          data_d    = entry(acc_nxt[0], part_nxt[0]);
        end
      end
      default: begin
        if (cnt_q[5]) begin
          irq_d     = |snap_q;
          dump_st_d = D_IDLE;
        end else begin
          wr_d   = 1'b1;
          addr_d = COLL_BASE + 7'(cnt_q[4:0]);
          data_d = entry(snap_q[cnt_q[4:0]], spart_q[cnt_q[4:0]]);
          cnt_d  = cnt_q + 6'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      line_st_q <= L_CLEAR;
      clr_x_q   <= '0;
      s1_vld_q  <= 1'b0;
      s1_x_q    <= '0;
      s1_idx_q  <= '0;
      fwd_q     <= 1'b0;
      fwd_idx_q <= '0;
      accum_q   <= '0;
      partner_q <= '0;
      snap_q    <= '0;
      spart_q   <= '0;
      dump_st_q <= D_IDLE;
      cnt_q     <= '0;
      vblank_q  <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      line_st_q <= line_st_d;
      clr_x_q   <= clr_x_d;
      s1_vld_q  <= s1_vld_d;
      s1_x_q    <= s1_x_d;
      s1_idx_q  <= s1_idx_d;
      fwd_q     <= fwd_d;
      fwd_idx_q <= fwd_idx_d;
      accum_q   <= accum_d;
      partner_q <= partner_d;
      snap_q    <= snap_d;
      spart_q   <= spart_d;
      dump_st_q <= dump_st_d;
      cnt_q     <= cnt_d;
      vblank_q  <= bus.vblank;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      irq_q     <= irq_d;
    end
  end

  assign bus.spritecollisionram_addr = addr_q;
  assign bus.spritecollisionram_data = data_q;
  assign bus.spritecollisionram_wr   = wr_q;
  assign bus.coll_irq                = irq_q;
  assign bus.busy                    = (line_st_q == L_CLEAR);
endmodule

// File: tb/tb_sprite_collision_detect.sv
// Scoreboard bench for sprite_collision_detect: a transaction-level model of the
// owner buffer / hit accumulation predicts each 32-entry dump, the expected
// RAM writes are queued when vblank is raised and popped by a write monitor.
module tb_sprite_collision_detect;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sprite_collision_detect_if bus();
  sprite_collision_detect #(.LINE_MAX(352), .COLL_BASE(7'd0)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // reference model
  bit         mo_v [512];
  logic [4:0] mo_i [512];
  bit  [31:0] m_acc;
  logic [4:0] m_part [32];

  logic [14:0] exp_q [$];
  int  exp_irq, irq_cnt, irq_cyc, first_wr_cyc, rise_cyc, wr_total, cyc;
  bit  dump_first;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    logic [14:0] e;
    if (bus.spritecollisionram_wr) begin
      wr_total++;
      if (dump_first) begin first_wr_cyc = cyc; dump_first = 0; end
      chk("wr_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ram_addr", 32'(bus.spritecollisionram_addr), 32'(e[14:8]));
        chk("ram_data", 32'(bus.spritecollisionram_data), 32'(e[7:0]));
      end
    end
    if (bus.coll_irq) begin irq_cnt++; irq_cyc = cyc; end
  end

  task automatic clear_line_model();
    for (int i = 0; i < 512; i++) mo_v[i] = 0;
  endtask

  task automatic clear_frame_model();
    m_acc = '0;
    for (int i = 0; i < 32; i++) m_part[i] = 5'd0;
  endtask

  task automatic drive_pix(input int x, input int idx);
    logic [4:0] p;
    if (mo_v[x] && mo_i[x] != 5'(idx)) begin
      p = mo_i[x];
      if (!m_acc[idx]) m_part[idx] = p;
      if (!m_acc[p])   m_part[p]   = 5'(idx);
      m_acc[idx] = 1'b1;
      m_acc[p]   = 1'b1;
    end
    mo_v[x] = 1;
    mo_i[x] = 5'(idx);
    bus.pix_wr = 1'b1;
    bus.pix_x = 9'(x);
    bus.pix_index = 5'(idx);
    @(negedge clk);
    bus.pix_wr = 1'b0;
  endtask

  task automatic wait_clear(input string tag);
    int t = 0;
    while (bus.busy && t < 1000) begin t++; @(negedge clk); end
    chk(tag, t, 353);
  endtask

  task automatic new_line();
    bus.line_start = 1'b1;
    @(negedge clk);
    bus.line_start = 1'b0;
    clear_line_model();
    wait_clear("line_clear_len");
  endtask

  task automatic start_dump();
    for (int i = 0; i < 32; i++)
      exp_q.push_back({7'(i), m_acc[i], 2'b00, (m_acc[i] ? m_part[i] : 5'd0)});
    exp_irq = (m_acc != 0) ? 1 : 0;
    clear_frame_model();
    irq_cnt = 0;
    first_wr_cyc = -100;
    dump_first = 1;
    bus.vblank = 1'b1;
    rise_cyc = cyc;
    @(negedge clk);
    bus.vblank = 1'b0;
  endtask

  task automatic finish_dump(input string tag);
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin t++; @(negedge clk); end
    chk({tag, "_drained"}, exp_q.size(), 0);
    repeat (4) @(negedge clk);
    chk({tag, "_irq_cnt"}, irq_cnt, exp_irq);
    chk({tag, "_first_wr_lat"}, first_wr_cyc - rise_cyc, 1);
    if (exp_irq != 0) chk({tag, "_irq_lat"}, irq_cyc - rise_cyc, 33);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.line_start = 0; bus.pix_wr = 0; bus.pix_x = 0; bus.pix_index = 0; bus.vblank = 0;
    clear_line_model();
    clear_frame_model();
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 1);
    chk("rst_wr", bus.spritecollisionram_wr, 0);
    chk("rst_irq", bus.coll_irq, 0);
    chk("rst_addr", 32'(bus.spritecollisionram_addr), 0);
    chk("rst_data", 32'(bus.spritecollisionram_data), 0);

    // 1: post-reset clear sweep
    reset = 1'b1;
    wait_clear("reset_busy_len");
    chk("reset_no_wr", wr_total, 0);

    // 2: overlapping runs of sprites 3 and 7
    for (int x = 100; x <= 115; x++) drive_pix(x, 3);
    for (int x = 110; x <= 125; x++) drive_pix(x, 7);
    chk("t2_model3", 32'({m_acc[3], 2'b00, m_part[3]}), 32'h87);
    chk("t2_model7", 32'({m_acc[7], 2'b00, m_part[7]}), 32'h83);
    start_dump();
    finish_dump("t2");

    // 3: back-to-back forward path, then self-overlap
    new_line();
    drive_pix(50, 1);
    drive_pix(50, 2);
    start_dump();
    finish_dump("t3a");
    new_line();
    drive_pix(50, 1);
    drive_pix(50, 1);
    start_dump();
    finish_dump("t3b");

    // 4: first partner kept
    new_line();
    drive_pix(30, 4);
    @(negedge clk);
    drive_pix(30, 9);
    drive_pix(40, 4);
    drive_pix(40, 12);
    start_dump();
    finish_dump("t4");

    // 5: same x on different lines is not a hit
    new_line();
    drive_pix(20, 2);
    new_line();
    drive_pix(20, 5);
    start_dump();
    finish_dump("t5");

    // 6: hit on the vblank rise cycle, then hit during dump
    new_line();
    drive_pix(60, 10);
    drive_pix(60, 11);
    start_dump();
    drive_pix(70, 13);
    drive_pix(70, 14);
    finish_dump("t6a");
    start_dump();
    finish_dump("t6b");

    // 7: random traffic in a narrow window
    new_line();
    for (int i = 0; i < 40; i++) drive_pix(int'($urandom_range(0, 15)), int'($urandom_range(0, 31)));
    drive_pix(400, 8);
    drive_pix(400, 9);
    start_dump();
    finish_dump("t7");

    // 8: reset in the middle of a dump
    new_line();
    drive_pix(5, 1);
    drive_pix(5, 2);
    start_dump();
    drive_pix(6, 3);
    drive_pix(6, 4);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1 exp_q.delete();
    clear_frame_model();
    clear_line_model();
    repeat (3) @(negedge clk);
    chk("abort_wr_low", bus.spritecollisionram_wr, 0);
    chk("abort_busy", bus.busy, 1);
    reset = 1'b1;
    wait_clear("abort_busy_len");
    chk("abort_no_irq", irq_cnt, 0);
    start_dump();
    finish_dump("t8");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
